veda_mem: RTL
=============

# veda_mem

Parametrised successor to the processor's data memory: a DEPTH x DATA_W word store serving the sort core through a valid/ready request channel and a one-deep registered response channel. Provides byte-lane writes, 1-cycle registered reads, out-of-range error reporting, and a hardware sweep engine that initialises the whole array after reset or on a wipe command. Sits between the processor datapath and nothing else; single clock domain.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 32, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH)+1, request address width; one spare bit so out-of-range addresses are expressible
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready at a rising edge
- req_op  input  6  OP_SCRIBBLE=6'b001110 write, OP_PEEK=6'b001111 read, OP_WIPE=6'b010000 sweep; anything else accepted and dropped
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- req_be  input  DATA_W/8  byte-lane enables for OP_SCRIBBLE; bit k covers wdata[8k+7:8k]
- rsp_valid  output  1  read response held until rsp_ready
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  DATA_W  read data; 0 when rsp_err
- rsp_err  output  1  read address >= DEPTH
- busy  output  1  sweep in progress

## Operation
- States: SWEEP, IDLE. rst forces SWEEP, sweep_ptr=0, rsp_valid=0, rsp_err=0, rsp_data=0; no array write on an edge where rst is high.
- SWEEP: each edge writes sweep value to cell[sweep_ptr], increments ptr; edge writing DEPTH-1 moves to IDLE. busy=1, req_ready=0.
- IDLE: req_ready = !rsp_valid || rsp_ready.
- OP_SCRIBBLE: addr < DEPTH updates enabled lanes at accept edge; disabled lanes keep value; addr >= DEPTH silently dropped. No response.
- OP_PEEK: captures cell[addr] into response register at accept edge; addr >= DEPTH gives rsp_err=1, rsp_data=0.
- OP_WIPE: at accept edge enter SWEEP with ptr=0; no response. A pending response stays valid and stable until consumed.
- Response register: cleared (rsp_valid=0) on rsp_ready edge unless a new read is accepted the same edge, in which case it loads the new data.
- Unknown opcodes: accepted, no state change, no response.

## Timing
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_data=0, rsp_err=0.
- rst released before edge E0: sweep writes on E0..E(DEPTH-1); req_ready=1 after E(DEPTH-1). Same DEPTH-cycle window after an accepted OP_WIPE.
- Read latency: rsp_valid rises after the accept edge; full throughput of one read per cycle when rsp_ready held high.
- Write at edge N, read of same address accepted at edge N+1 returns the new data (write-before-read; no bypass needed since reads sample after write).
- rst mid-sweep restarts sweep at ptr 0; rst with response pending drops it.
- rsp_valid high and rsp_ready low: req_ready=0, response fields frozen.

## Configuration
- VEDA_PRELOAD_EN defined: sweep value for cell i is 10*(i+1) for i<=10, 0 otherwise (test-program data set).
- Undefined: sweep writes 0 to every cell.

## Structure
- veda_pkg: opcode constants OP_SCRIBBLE, OP_PEEK, OP_WIPE; state enum {SWEEP, IDLE}; PRELOAD_COUNT=11 and preload function.
- One sub-module veda_sweeper: owns sweep_ptr, SWEEP/IDLE state, produces sweep address/data/write-enable and busy; top level muxes sweep vs. request writes into the array.

## Test plan
- Reset, DATA_W=32, DEPTH=32: busy=1 for exactly 32 cycles, then PEEK addr 3 -> 0 (or 40 with VEDA_PRELOAD_EN).
- SCRIBBLE addr 5 data 0xAABBCCDD be=4'b0101 over 0x11223344 -> PEEK addr 5 returns 0x11BB33DD.
- PEEK addr 40 (>= DEPTH) -> rsp_err=1, rsp_data=0; SCRIBBLE addr 40 leaves all cells unchanged.
- Back-to-back PEEK 0,1,2 with rsp_ready stalled 3 cycles after first -> req_ready=0 during stall, responses 10,20,30 in order, none lost.
- SCRIBBLE addr 7 = 99 then WIPE -> busy for 32 cycles, PEEK addr 7 returns 0 (80 with VEDA_PRELOAD_EN).
- Assert rst at sweep ptr 12 -> sweep restarts at 0, completes 32 cycles after rst release.

Source files
------------

// File: rtl/veda_pkg.sv
// veda_pkg: shared opcodes, sweeper state encoding and the preload data set
// used by the veda_mem data memory. Preload data is selected with the
// VEDA_PRELOAD_EN macro (see veda_sweeper).
package veda_pkg;

  localparam logic [5:0] OP_SCRIBBLE = 6'b001110;
  localparam logic [5:0] OP_PEEK     = 6'b001111;
  localparam logic [5:0] OP_WIPE     = 6'b010000;

  localparam int unsigned PRELOAD_COUNT = 11;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Test-program data set: cell i holds 10*(i+1) for the first PRELOAD_COUNT cells.
  function automatic logic [31:0] preload(input logic [31:0] idx);
    logic [31:0] v;
    if (idx < 32'(PRELOAD_COUNT)) begin
      v = (idx + 32'd1) * 32'd10;
    end else begin
      v = 32'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/veda_sweeper.sv
// veda_sweeper: walks every cell of the array once after reset or a wipe,
// supplying address, data and write enable to the top-level write mux.
// Build option: VEDA_PRELOAD_EN selects the preload data set instead of zeros.
module veda_sweeper
  import veda_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_we,
  output logic [IDX_W-1:0]  o_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_busy;

  // Sweep FSM: reset and wipe restart at cell 0; the edge writing the last cell returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SWEEP;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        SWEEP: begin
          if (r_ptr == LAST_IDX) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (i_start) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= SWEEP;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Sweep write port; suppressed while rst is high so reset edges never touch the array.
  always_comb begin
    o_busy = r_busy;
    o_we   = r_busy && !rst;
    o_addr = r_ptr;
`ifdef VEDA_PRELOAD_EN
    o_data = DATA_W'(preload(32'(r_ptr)));
`else
    o_data = '0;
`endif
  end

endmodule

// File: rtl/veda_mem.sv
// veda_mem: DEPTH x DATA_W data memory for the sort core. Valid/ready request
// channel (write / read / wipe), one-deep registered read response with
// out-of-range error, and a hardware sweep that initialises the array.
// Build option: VEDA_PRELOAD_EN (sweep loads the test-program data set).
module veda_mem
  import veda_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_busy;
  logic              w_sweep_we;
  logic [IDX_W-1:0]  w_sweep_addr;
  logic [DATA_W-1:0] w_sweep_data;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_wipe;

  veda_sweeper #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_sweeper (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_wipe),
    .o_busy  (w_busy),
    .o_we    (w_sweep_we),
    .o_addr  (w_sweep_addr),
    .o_data  (w_sweep_data)
  );

  // Request decode; a pending unconsumed response back-pressures the request channel.
  always_comb begin
    w_req_ready = !w_busy && (!r_rsp_valid || rsp_ready);
    w_accept    = req_valid && w_req_ready;
    w_in_range  = (req_addr < ADDR_W'(DEPTH));
    w_idx       = req_addr[IDX_W-1:0];
    w_wr_en     = w_accept && (req_op == OP_SCRIBBLE) && w_in_range;
    w_rd_en     = w_accept && (req_op == OP_PEEK);
    w_wipe      = w_accept && (req_op == OP_WIPE);
  end

  // Array write port: the sweep owns it while busy, otherwise byte-lane request writes.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= w_sweep_data;
    end else if (w_wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (req_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Response register: loads on an accepted read, clears when consumed, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_rd_en) begin
      r_rsp_valid <= 1'b1;
      if (w_in_range) begin
        r_rsp_data <= r_mem[w_idx];
        r_rsp_err  <= 1'b0;
      end else begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = w_busy;

endmodule
